// File: rtl/mux4_rr_select.sv
// mux4_rr_select: round-robin select generator for a 4:1 tristate mux stage.
// Grants one requester at a time and keeps one idle cycle between grants
// so that two tristate enables can never overlap. Each grant is ended
// after MAX_HOLD cycles if the owner does not release it first.
module mux4_rr_select #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] s,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_HOLD);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [1:0]    ptr_r;
    logic [1:0]    next_ptr_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] next_cnt_s;
    logic [1:0]    next_s_s;
    logic [3:0]    next_grant_s;
    logic          next_busy_s;
    logic          next_timeout_s;
    logic [1:0]    winner_s;

    // First set request bit scanning from the pointer upward, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] win;
        win = 2'b00;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                win = idx;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // Decode a 2-bit index into a one-hot tristate enable.
    function automatic logic [3:0] one_hot(input logic [1:0] idx);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Round-robin winner for the current pointer and request vector.
    always_comb begin
        winner_s = rr_pick(req, ptr_r);
    end

    // Next-state and next-output decode for the IDLE/GRANT controller.
    always_comb begin
        next_state_s   = state_r;
        next_ptr_s     = ptr_r;
        next_cnt_s     = cnt_r;
        next_s_s       = s;
        next_grant_s   = grant;
        next_busy_s    = busy;
        next_timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 4'b0000) begin
                    next_state_s = GRANT;
                    next_s_s     = winner_s;
                    next_grant_s = one_hot(winner_s);
                    next_busy_s  = 1'b1;
                    next_cnt_s   = CW'(1);
                end else begin
                    next_grant_s = 4'b0000;
                    next_busy_s  = 1'b0;
                end
            end
            GRANT: begin
                // Voluntary release (done or request dropped) beats the hold limit.
                if (done || !req[s] || (cnt_r == MAX_CNT)) begin
                    next_state_s   = IDLE;
                    next_grant_s   = 4'b0000;
                    next_busy_s    = 1'b0;
                    next_ptr_s     = s + 2'd1;
                    next_cnt_s     = '0;
                    next_timeout_s = !(done || !req[s]);
                end else begin
                    next_cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                next_state_s = IDLE;
                next_grant_s = 4'b0000;
                next_busy_s  = 1'b0;
                next_cnt_s   = '0;
            end
        endcase
    end

    // Controller state, pointer, hold counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= 2'b00;
            cnt_r   <= '0;
            s       <= 2'b00;
            grant   <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ptr_r   <= next_ptr_s;
            cnt_r   <= next_cnt_s;
            s       <= next_s_s;
            grant   <= next_grant_s;
            busy    <= next_busy_s;
            timeout <= next_timeout_s;
        end
    end

endmodule

// File: tb/tb_mux4_rr_select.sv
// Self-checking bench for mux4_rr_select with MAX_HOLD=4.
module tb_mux4_rr_select;

    localparam int MAXH = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] s;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index or -1 when nobody holds the mux.
    int m_owner;
    int m_s;
    int m_ptr;
    int m_hold;
    int m_to;

    logic [3:0] prev_grant;

    mux4_rr_select #(.MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .s(s), .grant(grant), .busy(busy), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] m_grant();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_s = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    endtask

    // Advance one clock and step the model with the inputs seen at that edge.
    task automatic tick();
        logic [3:0] r;
        logic d;
        r = req; d = done;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            m_to = 0;
            if (r != 4'b0000) begin
                for (int k = 3; k >= 0; k--)
                    if (r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
                m_s = m_owner;
                m_hold = 1;
            end
        end else begin
            if (d || !r[m_owner] || m_hold == MAXH) begin
                m_to = (d || !r[m_owner]) ? 0 : 1;
                m_owner = -1;
                m_ptr = (m_s + 1) % 4;
                m_hold = 0;
            end else begin
                m_hold++;
            end
        end
        #1;
    endtask

    task automatic go_idle();
        req = 4'b0000; done = 1'b1;
        tick(); tick();
        done = 1'b0;
    endtask

    // Structural invariants, sampled every falling edge outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((grant & (grant - 4'd1)) !== 4'b0000) begin
                errors++; $display("FAIL onehot grant=%b", grant);
            end
            checks++;
            if (busy !== (grant != 4'b0000)) begin
                errors++; $display("FAIL busy_vs_grant busy=%b grant=%b", busy, grant);
            end
            if (busy) begin
                checks++;
                if (grant !== (4'b0001 << s)) begin
                    errors++; $display("FAIL grant_vs_s grant=%b s=%0d", grant, s);
                end
            end
            if (grant != 4'b0000 && prev_grant != 4'b0000) begin
                checks++;
                if (grant !== prev_grant) begin
                    errors++; $display("FAIL dead_cycle prev=%b now=%b", prev_grant, grant);
                end
            end
            prev_grant = grant;
        end else begin
            prev_grant = 4'b0000;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b0000; done = 1'b0;
        model_reset();
        tick(); tick();
        checks++;
        if ({s, grant, busy, timeout} !== 8'b0) begin
            errors++; $display("FAIL reset_values s=%0d grant=%b busy=%b timeout=%b want all 0", s, grant, busy, timeout);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0000) begin
            errors++; $display("FAIL reset_idle grant=%b want 0000", grant);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [9];
        exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        req = 4'b1111; done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (grant !== exp_seq[i] || grant !== m_grant()) begin
                errors++; $display("FAIL rotation step %0d grant=%b want %b", i, grant, exp_seq[i]);
            end
            if (grant != 4'b0000) begin
                checks++;
                if (s !== 2'(i / 2)) begin
                    errors++; $display("FAIL rotation_s step %0d s=%0d want %0d", i, s, (i / 2) % 4);
                end
            end
            done = (grant != 4'b0000);
        end
        go_idle();
    endtask

    task automatic test_wrap();
        req = 4'b1000; tick();
        checks++;
        if (s !== 2'd3 || grant !== 4'b1000) begin
            errors++; $display("FAIL wrap_setup s=%0d grant=%b want 3/1000", s, grant);
        end
        done = 1'b1; tick(); done = 1'b0;
        req = 4'b0101; tick();
        checks++;
        if (s !== 2'd0 || grant !== 4'b0001) begin
            errors++; $display("FAIL wrap_3_to_0 s=%0d grant=%b want 0/0001", s, grant);
        end
        done = 1'b1; tick(); done = 1'b0;
        tick();
        checks++;
        if (s !== 2'd2 || grant !== 4'b0100) begin
            errors++; $display("FAIL wrap_0_to_2 s=%0d grant=%b want 2/0100", s, grant);
        end
        go_idle();
    endtask

    task automatic test_timeout();
        logic [3:0] exp_g [6];
        logic       exp_t [6];
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010};
        exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        req = 4'b0010; done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (grant !== exp_g[i] || timeout !== exp_t[i]) begin
                errors++; $display("FAIL timeout step %0d grant=%b timeout=%b want %b/%b", i, grant, timeout, exp_g[i], exp_t[i]);
            end
        end
        go_idle();
    endtask

    task automatic test_simultaneous();
        req = 4'b0001; done = 1'b0;
        for (int i = 0; i < MAXH; i++) tick();
        done = 1'b1; tick();
        checks++;
        if (grant !== 4'b0000 || timeout !== 1'b0) begin
            errors++; $display("FAIL done_at_limit grant=%b timeout=%b want 0000/0", grant, timeout);
        end
        go_idle();
        req = 4'b0100; tick(); tick();
        req = 4'b0000; tick();
        checks++;
        if (grant !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL req_drop grant=%b timeout=%b busy=%b want 0000/0/0", grant, timeout, busy);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++; $display("FAIL req_drop_pulse timeout=%b want 0", timeout);
        end
    endtask

    task automatic test_reset_midgrant();
        go_idle();
        req = 4'b0100; tick();
        checks++;
        if (grant !== 4'b0100) begin
            errors++; $display("FAIL midgrant_setup grant=%b want 0100", grant);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || s !== 2'd0 || timeout !== 1'b0) begin
            errors++; $display("FAIL async_reset grant=%b busy=%b s=%0d timeout=%b want 0", grant, busy, s, timeout);
        end
        tick();
        rst_n = 1'b1; req = 4'b1000; tick();
        checks++;
        if (s !== 2'd3 || grant !== 4'b1000) begin
            errors++; $display("FAIL after_reset s=%0d grant=%b want 3/1000", s, grant);
        end
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 4) == 0);
            tick();
            checks++;
            if (grant !== m_grant() || s !== 2'(m_s) || busy !== (m_owner >= 0) || timeout !== 1'(m_to)) begin
                errors++; $display("FAIL random cyc %0d s=%0d grant=%b busy=%b to=%b want %0d/%b/%0d/%0d",
                    i, s, grant, busy, timeout, m_s, m_grant(), (m_owner >= 0), m_to);
            end
        end
    endtask

    initial begin
        prev_grant = 4'b0000;
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_simultaneous();
        test_reset_midgrant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_select.md
# mux4_rr_select

Round-robin select generator that drives the 2-bit select and one-hot enables of the 4:1 decoder/tristate-buffer mux stage. It arbitrates four request lines and grants exactly one source at a time. It inserts a mandatory dead cycle between grants, so the downstream tristate buffers never see overlapping enables. It also bounds every grant with a hold timeout.

## Interface
- MAX_HOLD, 16, maximum consecutive grant cycles per winner; legal range 1..255
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  per-source request; req[i] high = source i wants the mux
- done  input  1  current owner releases the grant; sampled only while busy
- s  output  2  registered select to the mux stage; index of current/last winner
- grant  output  4  registered one-hot enable to the tristate buffers; all-zero when idle
- busy  output  1  high while a grant is active
- timeout  output  1  one-cycle pulse when a grant was forcibly ended by MAX_HOLD

## Operation
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Internal state: FSM {IDLE, GRANT}, 2-bit priority pointer ptr, hold counter cnt of width clog2(MAX_HOLD+1).
- Reset values:
  - state=IDLE, ptr=0, cnt=0
  - s=2'b00, grant=4'b0000, busy=0, timeout=0
  - Reset asserted mid-grant drops grant to zero immediately (async) and discards the pointer history.
- IDLE:
  - grant=0, busy=0; s holds the last winner.
  - If req != 0: the winner is the first set bit scanning ptr, ptr+1, ... (mod 4).
  - Next edge: s=winner, grant=one-hot(winner), busy=1, cnt=1, state=GRANT.
- GRANT: release conditions, evaluated each edge in priority order:
  1. done=1 → release; timeout stays 0.
  2. req[s]=0 → release; timeout stays 0.
  3. cnt==MAX_HOLD → release; timeout=1 on the next cycle.
  4. Otherwise hold the grant, cnt=cnt+1.
- Release action:
  - state=IDLE, grant=0, busy=0, ptr=s+1 (mod 4 wrap, 3→0), cnt=0.
  - s is unchanged.
- timeout:
  - High for exactly the first IDLE cycle after a forced release; low otherwise.
  - done and the limit in the same cycle → done wins, no timeout pulse.
- Invariants:
  - grant is always zero or exactly one-hot.
  - When grant != 0, grant == one-hot(s).
  - busy == |grant.
- Fairness: a continuously requesting source waits at most 3 other grants before it is served.

## Timing
- Arbitration latency: req seen at edge N → grant visible after edge N (one cycle, registered).
- Dead cycle:
  - At least one cycle with grant=0 between any two grants, including back-to-back requests and re-grant of the same source.
  - Minimum grant-to-grant period is 2 cycles.
- Grant length:
  - Minimum 1 cycle (release sampled at the first GRANT edge).
  - Maximum MAX_HOLD cycles.
  - MAX_HOLD=1 gives exactly 1-cycle grants with timeout pulses whenever req stays high and done=0.
- done and req are sampled synchronously. Glitches between edges are ignored. done during IDLE has no effect.
- All outputs come directly from flops; there is no combinational path from input to output.

## Test plan
- **Reset:** assert rst_n=0 mid-grant (grant=4'b0100) → grant=0, busy=0, s=0, timeout=0 asynchronously; after release with req=4'b1000 → s=3, grant=4'b1000 one cycle later.
- **Rotation:** req=4'b1111 held, done pulsed 1 cycle after each grant:
  - grants in order 0001, 0010, 0100, 1000, 0001
  - grant=0 for one cycle between each
  - s follows 0,1,2,3,0.
- **Pointer wrap:** after a grant to source 3 with req=4'b0101 → next winner is 0 (s=0); after a grant to source 0 with req=4'b0101 → next winner is 2.
- **Timeout:** MAX_HOLD=4, req=4'b0010 held, done=0:
  - grant=0010 for exactly 4 cycles
  - then IDLE with timeout=1 for 1 cycle
  - then re-grant of 0010.
- **Simultaneous events:** at cnt==MAX_HOLD assert done=1 → release with timeout=0. Drop req[s] with done=0 at cnt=2 → release after that edge, timeout=0.
- **Checker, run on all scenarios:**
  - grant is one-hot or zero every cycle
  - grant==one-hot(s) whenever busy=1
  - no cycle has a nonzero grant immediately following a different nonzero grant.
